regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (we3/ra3/wd3) between NREQ writeback requesters, for example the ALU result path and the load-data return path.
- Each requester uses a valid/ready handshake; one write is granted per cycle by round-robin.
- The winning write is registered, then driven to the register file one cycle after acceptance.
- Writes to R15 are rejected here, because the register file has no R15 storage (PC is supplied externally).

Parameters:
- NREQ, 2, number of write requesters (2..4)
- AW, 4, register address width
- DW, 32, write data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  packed destination addresses; slice i = [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; slice i = [i*DW +: DW]
- req_ready  out  NREQ  combinational grant; the write is accepted when valid and ready are both high
- we3  out  1  register-file write enable (registered)
- wa3  out  AW  register-file write address, drives ra3 (registered)
- wd3  out  DW  register-file write data (registered)
- grant_id  out  clog2(NREQ)  index of the requester whose write is on we3/wa3/wd3
- r15_drop  out  1  one-cycle pulse: an accepted write targeted address 15 and was discarded

Behaviour:
- Reset: we3=0, wa3=0, wd3=0, grant_id=0, r15_drop=0, rr pointer=0 (requester 0 highest priority).
  - During reset, req_ready=0 for all requesters.
- Arbitration is round-robin.
  - Priority order starts at the rr pointer and wraps modulo NREQ.
  - The first requester with req_valid=1 in that order is the winner; req_ready is one-hot or zero.
- The register file never back-pressures, so a valid request always yields exactly one grant that cycle.
- Pointer update: after a grant to requester i, pointer = (i+1) mod NREQ. With no grant, the pointer holds.
- Latency: a write accepted in cycle N appears on we3/wa3/wd3 in cycle N+1 and is committed at the edge ending N+1.
  - No grant in cycle N gives we3=0 in N+1.
  - wa3/wd3 hold their last values when we3=0.
- R15 handling: a granted request with addr=4'hF is still acknowledged (ready=1).
  - In N+1: we3=0, r15_drop=1, grant_id=i.
  - It still advances the pointer.
- Same-address requests in the same cycle: only the winner is accepted; the loser stays pending and is written in a later cycle. Order equals grant order.
- Fairness bound: with all requesters continuously valid and no lock, any requester waits at most NREQ-1 cycles.
- Requesters must hold addr/data stable while valid and not ready. Dropping valid before acceptance is permitted.
- Reset asserted mid-operation:
  - The output stage clears on the next edge, so an in-flight write is not committed.
  - Pending requests are not acknowledged.

Optional Feature:
- Macro: RW_ARB_LOCK_EN.
- Defined:
  - Adds port req_lock (in, NREQ).
  - If the requester granted in cycle N has req_lock[i]=1 and req_valid[i]=1 in N+1, it is granted again regardless of the pointer. This supports load-multiple bursts.
  - The pointer advances only when a grant occurs without lock continuation.
  - The lock is honoured for at most 16 consecutive grants. After that, the round-robin order is forced for one arbitration.
- Undefined:
  - The port is absent; pure round-robin; the fairness bound always holds.

Decomposition:
- Package rw_arb_pkg holds:
  - REG_AW=4, REG_DW=32
  - PC_REG=4'hF
  - LOCK_MAX=16
  - typedef wr_req_t {logic [3:0] addr; logic [31:0] data;}
- Sub-module rr_arbiter (parameter N) holds:
  - Inputs: req[N] and an advance enable.
  - Outputs: one-hot gnt[N] and the binary index.
  - It owns the rr pointer.
  - The top level adds the output register stage, R15 filtering and the optional lock.

Test Plan:
- Reset, then req0 valid with addr=3, data=32'hDEADBEEF → ready0=1 in cycle N; in N+1 we3=1, wa3=3, wd3=32'hDEADBEEF, grant_id=0.
- req0 and req1 continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1; we3 high in every following cycle.
- req0 (addr=5, data=1) and req1 (addr=5, data=2) valid in the same cycle with pointer=0 → R5 written with 1 then 2 on consecutive cycles; final register value 2.
- req1 addr=15, data=7 → ready1=1; next cycle we3=0, r15_drop=1; pointer moves to 0.
- Reset asserted in the cycle after a grant → we3=0 after the edge; a register-file readback of the target address shows it unchanged.
- (RW_ARB_LOCK_EN) req1 locked with 20 writes while req0 continuously valid → req1 gets 16 consecutive grants, then req0 gets 1, then req1 resumes.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Contents: address/data widths, PC register index, lock burst limit, request record.
// Also provides idx_w(), the width of a binary requester index.
package rw_arb_pkg;

  localparam int          REG_AW   = 4;
  localparam int          REG_DW   = 32;
  localparam logic [3:0]  PC_REG   = 4'hF;
  localparam int          LOCK_MAX = 16;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

  // Binary index width; a single requester still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus shared by NREQ requesters (valid/ready per requester).
// master: drives valid/addr/data (and lock when RW_ARB_LOCK_EN); slave: returns ready.
// Slices: requester i owns addr[i*AW +: AW] and data[i*DW +: DW].
interface regfile_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
`ifdef RW_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif

  modport master (
    output
`ifdef RW_ARB_LOCK_EN
           req_lock,
`endif
           req_valid, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input
`ifdef RW_ARB_LOCK_EN
           req_lock,
`endif
           req_valid, req_addr, req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Round-robin arbiter owning the rotating priority pointer.
// Ports: clk/reset, req[N], advance (allow pointer update), gnt[N] one-hot, idx binary.
// Grant is combinational; pointer moves to idx+1 on a granted cycle with advance high.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // Scan N slots starting at ptr, wrapping; first requester found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NREQ writeback requesters.
// Ports: clk/reset, request bus (slave modport), we3/wa3/wd3 write port, grant_id, r15_drop.
// Optional macro RW_ARB_LOCK_EN adds req_lock burst continuation (max LOCK_MAX grants).
module regfile_write_arbiter
  import rw_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus,
  output logic                   we3,
  output logic [AW-1:0]          wa3,
  output logic [DW-1:0]          wd3,
  output logic [IW-1:0]          grant_id,
  output logic                   r15_drop
);

  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   sel;
  logic            advance;
  logic            any_gnt;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            is_pc;
  logic            we3_q;

  // Nothing is acknowledged while reset is held.
  assign rr_req = bus.req_valid & {NREQ{~reset}};

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (rr_req),
    .advance (advance),
    .gnt     (rr_gnt),
    .idx     (rr_idx)
  );

`ifdef RW_ARB_LOCK_EN
  logic       got_q;     // a grant happened last cycle; grant_id names it
  logic [4:0] lock_cnt;  // consecutive grants in the current lock run
  logic       lock_hit;

  assign lock_hit = !reset && got_q && bus.req_valid[grant_id] &&
                    bus.req_lock[grant_id] && (lock_cnt < 5'(LOCK_MAX));
  assign gnt      = lock_hit ? (NREQ'(1) << grant_id) : rr_gnt;
  assign sel      = lock_hit ? grant_id : rr_idx;
  // A lock continuation leaves the pointer where the run started.
  assign advance  = !lock_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      got_q    <= 1'b0;
      lock_cnt <= '0;
    end else begin
      got_q <= any_gnt;
      if (any_gnt) lock_cnt <= lock_hit ? lock_cnt + 5'd1 : 5'd1;
    end
  end
`else
  assign gnt     = rr_gnt;
  assign sel     = rr_idx;
  assign advance = 1'b1;
`endif

  assign any_gnt       = |gnt;
  assign bus.req_ready = gnt;

  assign win_addr = bus.req_addr[int'(sel)*AW +: AW];
  assign win_data = bus.req_data[int'(sel)*DW +: DW];
  // R15 has no storage in the register file: acknowledge, but never write it.
  assign is_pc    = (win_addr == AW'(PC_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q    <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      grant_id <= '0;
      r15_drop <= 1'b0;
    end else begin
      we3_q    <= any_gnt && !is_pc;
      r15_drop <= any_gnt && is_pc;
      if (any_gnt) grant_id <= sel;
      // Address/data only move on a real write, so they hold through idle and R15 drops.
      if (any_gnt && !is_pc) begin
        wa3 <= win_addr;
        wd3 <= win_data;
      end
    end
  end

  // The register file commits on the edge ending the cycle we3 is high; masking with
  // reset keeps an in-flight write from landing when reset arrives that cycle.
  assign we3 = we3_q & ~reset;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [0:0]  grant_id;
  logic        r15_drop;
  logic        rf_clr;
  logic [31:0] regs [16];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NREQ(2), .AW(4), .DW(32)) bus ();

  regfile_write_arbiter #(.NREQ(2), .AW(4), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .grant_id (grant_id),
    .r15_drop (r15_drop)
  );

  // Register file model: commits we3 writes on the rising edge.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int r = 0; r < 16; r++) regs[r] <= 32'h0;
    end else if (we3) begin
      regs[wa3] <= wd3;
    end
  end

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        gid;
    logic        drop;
  } vec_t;

  vec_t vt [15];

  function automatic vec_t mk(logic [1:0] v, logic [3:0] a0, logic [31:0] d0,
                              logic [3:0] a1, logic [31:0] d1, logic [1:0] rdy,
                              logic we, logic [3:0] wa, logic [31:0] wd,
                              logic gid, logic drop);
    vec_t r;
    r.v = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.gid = gid; r.drop = drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                       input logic [3:0] a1, input logic [31:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  initial begin
    // Expected grant sequence starts with the pointer at 0 after reset.
    vt[0]  = mk(2'b01, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0,  2'b01, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    vt[1]  = mk(2'b11, 4'd1, 32'h10, 4'd2, 32'h20,      2'b10, 1'b1, 4'd2, 32'h20, 1'b1, 1'b0);
    vt[2]  = mk(2'b11, 4'd1, 32'h10, 4'd2, 32'h20,      2'b01, 1'b1, 4'd1, 32'h10, 1'b0, 1'b0);
    vt[3]  = vt[1];
    vt[4]  = vt[2];
    vt[5]  = vt[1];
    vt[6]  = vt[2];
    vt[7]  = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0,        2'b00, 1'b0, 4'd1, 32'h10, 1'b0, 1'b0);
    vt[8]  = mk(2'b01, 4'd7, 32'h77, 4'd0, 32'h0,       2'b01, 1'b1, 4'd7, 32'h77, 1'b0, 1'b0);
    vt[9]  = mk(2'b10, 4'd0, 32'h0, 4'd4, 32'h44,       2'b10, 1'b1, 4'd4, 32'h44, 1'b1, 1'b0);
    vt[10] = mk(2'b11, 4'd5, 32'h1, 4'd5, 32'h2,        2'b01, 1'b1, 4'd5, 32'h1, 1'b0, 1'b0);
    vt[11] = mk(2'b10, 4'd5, 32'h1, 4'd5, 32'h2,        2'b10, 1'b1, 4'd5, 32'h2, 1'b1, 1'b0);
    vt[12] = mk(2'b10, 4'd0, 32'h0, 4'd15, 32'h7,       2'b10, 1'b0, 4'd5, 32'h2, 1'b1, 1'b1);
    vt[13] = mk(2'b11, 4'd6, 32'h66, 4'd8, 32'h88,      2'b01, 1'b1, 4'd6, 32'h66, 1'b0, 1'b0);
    vt[14] = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0,        2'b00, 1'b0, 4'd6, 32'h66, 1'b0, 1'b0);

    // Reset with both requesters valid: nothing may be acknowledged.
    reset  = 1'b1;
    rf_clr = 1'b1;
`ifdef RW_ARB_LOCK_EN
    bus.req_lock = 2'b00;
`endif
    drive(2'b11, 4'd1, 32'h11, 4'd2, 32'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_we3", 32'(we3), 32'h0);
    chk("reset_wa3", 32'(wa3), 32'h0);
    chk("reset_wd3", wd3, 32'h0);
    chk("reset_gid", 32'(grant_id), 32'h0);
    chk("reset_drop", 32'(r15_drop), 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    rf_clr = 1'b0;
    drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we3", i), 32'(we3), 32'(vt[i].we));
      chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(vt[i].wa));
      chk($sformatf("v%0d_wd3", i), wd3, vt[i].wd);
      chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vt[i].gid));
      chk($sformatf("v%0d_drop", i), 32'(r15_drop), 32'(vt[i].drop));
    end

    // Register file contents: same-address writes in grant order, R15 never written.
    chk("rf_r3", regs[3], 32'hDEADBEEF);
    chk("rf_r5", regs[5], 32'h2);
    chk("rf_r15", regs[15], 32'h0);

    // Reset arriving in the cycle the write sits on we3: it must not commit.
    @(negedge clk);
    drive(2'b01, 4'd9, 32'h99, 4'd0, 32'h0);
    #1;
    chk("mid_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("mid_inflight_we3", 32'(we3), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 4'd10, 32'hA0, 4'd11, 32'hB0);
    #1;
    chk("mid_reset_we3", 32'(we3), 32'h0);
    chk("mid_reset_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_after_we3", 32'(we3), 32'h0);
    chk("mid_after_wa3", 32'(wa3), 32'h0);
    chk("mid_rf_r9", regs[9], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    // Pointer back at 0: requester 0 wins first.
    chk("post_reset_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post_reset_wa3", 32'(wa3), 32'hA);
    @(negedge clk);
    drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);

`ifdef RW_ARB_LOCK_EN
    // Locked burst from requester 1 against a continuously valid requester 0.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_lock = 2'b10;
    for (int c = 0; c < 18; c++) begin
      logic [1:0] exp_rdy;
      if (c > 0) @(negedge clk);
      drive((c == 0) ? 2'b10 : 2'b11, 4'd1, 32'h100, 4'd2, 32'(c));
      exp_rdy = (c < 16) ? 2'b10 : ((c == 16) ? 2'b01 : 2'b10);
      #1;
      chk($sformatf("lock_c%0d_ready", c), 32'(bus.req_ready), 32'(exp_rdy));
    end
    @(negedge clk);
    drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    bus.req_lock = 2'b00;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
